// File: rtl/rf2_32x128_wm1_rtl.sv
// Two-port 32x128 register file (read port A, bit-masked write port B) replacing the compiled macro.
// Optional RAM-bypass DFT path enabled by defining RF2_32X128_WM1_DFT_BYPASS_EN.
module rf2_32x128_wm1_rtl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         CENA,
    input  logic [4:0]   AA,
    output logic [127:0] QA,
    input  logic         CENB,
    input  logic [127:0] WENB,
    input  logic [4:0]   AB,
    input  logic [127:0] DB,
    input  logic [2:0]   EMAA,
    input  logic         EMASA,
    input  logic [2:0]   EMAB,
    input  logic         TENA,
    input  logic         TCENA,
    input  logic [4:0]   TAA,
    input  logic         TENB,
    input  logic         TCENB,
    input  logic [127:0] TWENB,
    input  logic [4:0]   TAB,
    input  logic [127:0] TDB,
    input  logic         RET1N,
    input  logic         DFTRAMBYP,
    input  logic         COLLDISN,
    output logic         CENYA,
    output logic [4:0]   AYA,
    output logic         CENYB,
    output logic [127:0] WENYB,
    output logic [4:0]   AYB
);

    localparam int unsigned WORDS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 128;

    logic [DW-1:0] mem [WORDS];

    logic          cen_a;
    logic [AW-1:0] addr_a;
    logic          cen_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wen_b;
    logic [DW-1:0] data_b;
    logic          bypass;
    logic          rd_en;
    logic          wr_en;
    logic          collide;
    logic [DW-1:0] merged;

    // Functional / test pin muxes; the muxed values are also exported on the Y pins.
    assign cen_a  = TENA ? CENA : TCENA;
    assign addr_a = TENA ? AA   : TAA;
    assign cen_b  = TENB ? CENB : TCENB;
    assign wen_b  = TENB ? WENB : TWENB;
    assign addr_b = TENB ? AB   : TAB;
    assign data_b = TENB ? DB   : TDB;

    assign CENYA = cen_a;
    assign AYA   = addr_a;
    assign CENYB = cen_b;
    assign WENYB = wen_b;
    assign AYB   = addr_b;

`ifdef RF2_32X128_WM1_DFT_BYPASS_EN
    assign bypass = DFTRAMBYP;

    logic unused_pins;
    assign unused_pins = ^{EMAA, EMASA, EMAB};
`else
    assign bypass = 1'b0;

    logic unused_pins;
    assign unused_pins = ^{EMAA, EMASA, EMAB, DFTRAMBYP};
`endif

    assign rd_en   = RET1N & ~cen_a;
    assign wr_en   = RET1N & ~cen_b & ~bypass;
    assign collide = wr_en & (addr_a == addr_b);
    // Word as it will look after this cycle's masked write (0 in WENB selects DB).
    assign merged  = (mem[addr_b] & wen_b) | (data_b & ~wen_b);

    // Array and read register; reset wins over any same-cycle access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                mem[AW'(i)] <= '0;
            end
            QA <= '0;
        end else if (RET1N) begin
            if (bypass) begin
                QA <= data_b;
            end else begin
                if (wr_en) begin
                    mem[addr_b] <= merged;
                end
                if (rd_en) begin
                    QA <= (collide && !COLLDISN) ? merged : mem[addr_a];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf2_32x128_wm1_rtl.sv
// Directed self-checking bench for rf2_32x128_wm1_rtl: reset, masked writes, hold, retention,
// collisions, test muxing and the optional RF2_32X128_WM1_DFT_BYPASS_EN path.
module tb_rf2_32x128_wm1_rtl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         CENA;
    logic [4:0]   AA;
    logic [127:0] QA;
    logic         CENB;
    logic [127:0] WENB;
    logic [4:0]   AB;
    logic [127:0] DB;
    logic [2:0]   EMAA;
    logic         EMASA;
    logic [2:0]   EMAB;
    logic         TENA;
    logic         TCENA;
    logic [4:0]   TAA;
    logic         TENB;
    logic         TCENB;
    logic [127:0] TWENB;
    logic [4:0]   TAB;
    logic [127:0] TDB;
    logic         RET1N;
    logic         DFTRAMBYP;
    logic         COLLDISN;
    logic         CENYA;
    logic [4:0]   AYA;
    logic         CENYB;
    logic [127:0] WENYB;
    logic [4:0]   AYB;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] ONES = {128{1'b1}};

    rf2_32x128_wm1_rtl dut (
        .clk(clk), .rst_n(rst_n),
        .CENA(CENA), .AA(AA), .QA(QA),
        .CENB(CENB), .WENB(WENB), .AB(AB), .DB(DB),
        .EMAA(EMAA), .EMASA(EMASA), .EMAB(EMAB),
        .TENA(TENA), .TCENA(TCENA), .TAA(TAA),
        .TENB(TENB), .TCENB(TCENB), .TWENB(TWENB), .TAB(TAB), .TDB(TDB),
        .RET1N(RET1N), .DFTRAMBYP(DFTRAMBYP), .COLLDISN(COLLDISN),
        .CENYA(CENYA), .AYA(AYA), .CENYB(CENYB), .WENYB(WENYB), .AYB(AYB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle away from the edge before checking or re-driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        CENA = 1'b1;
        CENB = 1'b1;
        WENB = ONES;
    endtask

    task automatic wr(input logic [4:0] a, input logic [127:0] wen, input logic [127:0] d);
        CENA = 1'b1;
        CENB = 1'b0;
        AB   = a;
        WENB = wen;
        DB   = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [4:0] a);
        CENA = 1'b0;
        AA   = a;
        CENB = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        rst_n = 1'b0; CENA = 1'b1; AA = '0; CENB = 1'b1; WENB = ONES; AB = '0; DB = '0;
        EMAA = 3'd2; EMASA = 1'b1; EMAB = 3'd5;
        TENA = 1'b1; TCENA = 1'b1; TAA = '0;
        TENB = 1'b1; TCENB = 1'b1; TWENB = ONES; TAB = '0; TDB = '0;
        RET1N = 1'b1; DFTRAMBYP = 1'b0; COLLDISN = 1'b1;
        #2;

        // Reset, then read
        tick();
        rst_n = 1'b1;
        check("reset_qa", QA, 128'h0);
        rd(5'h0a);
        check("reset_read", QA, 128'h0);

        // Masked write: only low 32 bits enabled
        wr(5'h0a, {{96{1'b1}}, 32'h0}, 128'h0000_0002_0000_0002_0000_0002_0000_0002);
        rd(5'h0a);
        check("masked_write", QA, 128'h2);

        // Mask merge
        wr(5'h03, 128'h0, ONES);
        wr(5'h03, {{120{1'b1}}, 8'h00}, 128'h0);
        rd(5'h03);
        check("mask_merge", QA, {{120{1'b1}}, 8'h00});

        // Hold with CENA=1
        AA = 5'h0a;
        tick();
        check("hold", QA, {{120{1'b1}}, 8'h00});

        // Retention blocks both ports
        RET1N = 1'b0;
        CENA = 1'b0; AA = 5'h0a;
        CENB = 1'b0; AB = 5'h03; WENB = 128'h0; DB = 128'h0;
        tick();
        idle();
        check("ret_qa_hold", QA, {{120{1'b1}}, 8'h00});
        RET1N = 1'b1;
        rd(5'h03);
        check("ret_mem_hold", QA, {{120{1'b1}}, 8'h00});

        // All-ones mask write is a no-op
        wr(5'h0a, ONES, 128'h0);
        rd(5'h0a);
        check("allones_mask", QA, 128'h2);

        // Independent read and write on different addresses
        CENA = 1'b0; AA = 5'h0a;
        CENB = 1'b0; AB = 5'h0b; WENB = 128'h0; DB = 128'hABCD;
        tick();
        idle();
        check("diff_addr_read", QA, 128'h2);
        rd(5'h0b);
        check("diff_addr_write", QA, 128'hABCD);

        // Collision, COLLDISN=1 returns old data
        COLLDISN = 1'b1;
        CENA = 1'b0; AA = 5'h07;
        CENB = 1'b0; AB = 5'h07; WENB = 128'h0; DB = ONES;
        tick();
        idle();
        check("coll_old", QA, 128'h0);
        rd(5'h07);
        check("coll_write_done", QA, ONES);

        // Collision, COLLDISN=0 returns merged data
        wr(5'h07, 128'h0, 128'h0);
        COLLDISN = 1'b0;
        CENA = 1'b0; AA = 5'h07;
        CENB = 1'b0; AB = 5'h07; WENB = 128'h0; DB = ONES;
        tick();
        idle();
        check("coll_merged", QA, ONES);
        COLLDISN = 1'b1;

        // Test mux on port B, then port A
        TENB = 1'b0; TCENB = 1'b0; TAB = 5'h1f; TWENB = 128'h0; TDB = 128'h5;
        #1;
        check("wenyb", WENYB, 128'h0);
        check("ayb", 128'(AYB), 128'h1f);
        check("cenyb", 128'(CENYB), 128'h0);
        tick();
        TENB = 1'b1; TCENB = 1'b1; TWENB = ONES;
        TENA = 1'b0; TCENA = 1'b0; TAA = 5'h1f; CENA = 1'b1; AA = 5'h00;
        #1;
        check("cenya", 128'(CENYA), 128'h0);
        check("aya", 128'(AYA), 128'h1f);
        tick();
        check("test_read", QA, 128'h5);
        TENA = 1'b1; TCENA = 1'b1;

        // DFT bypass request
        DFTRAMBYP = 1'b1;
        CENA = 1'b1; CENB = 1'b0; AB = 5'h0c; WENB = 128'h0; DB = ONES;
        tick();
        idle();
        DFTRAMBYP = 1'b0;
`ifdef RF2_32X128_WM1_DFT_BYPASS_EN
        check("byp_qa", QA, ONES);
        rd(5'h0c);
        check("byp_no_write", QA, 128'h0);
`else
        check("byp_ignored_qa", QA, 128'h5);
        rd(5'h0c);
        check("byp_ignored_write", QA, ONES);
`endif

        // Reset clears array and QA
        rst_n = 1'b0;
        CENB = 1'b0; AB = 5'h03; WENB = 128'h0; DB = ONES;
        tick();
        idle();
        rst_n = 1'b1;
        check("reset2_qa", QA, 128'h0);
        rd(5'h03);
        check("reset2_mem", QA, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
